voter3: RTL and testbench

- Three-input majority voter, one voter per input (a, b, c).
- Samples the three votes every clock cycle and registers the per-voter LED display, the yes-vote count and the majority result.
- Keeps saturating statistics counters for rounds voted and rounds passed.
- Leaf block driving board LEDs; no handshake with other logic.

---
 rtl/voter_pkg.sv | 16 +
 rtl/majority3.sv | 18 +
 rtl/voter3.sv | 66 ++++++
 tb/tb_voter3.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// Shared constants and types for the three-input majority voter.
package voter_pkg;

  // Number of voters on the panel (a, b, c).
  localparam int VOTERS = 3;

  // Default width of the rounds-voted / rounds-passed statistics counters.
  localparam int CNT_W_DEFAULT = 8;

  // Number of yes votes in a round, 0..3.
  typedef logic [1:0] yes_count_t;

  // Per-voter vote vector, bit0 = a, bit1 = b, bit2 = c.
  typedef logic [VOTERS-1:0] votes_t;

endpackage

// File: rtl/majority3.sv
// Combinational majority-of-three and yes-vote population count.
module majority3
  import voter_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       maj,
  output yes_count_t cnt
);

  // Count is formed at 2-bit width so 1+1+1 = 3 never overflows.
  always_comb begin
    cnt = yes_count_t'({1'b0, a}) + yes_count_t'({1'b0, b}) + yes_count_t'({1'b0, c});
    maj = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/voter3.sv
// Three-input majority voter driving board LEDs, with saturating
// rounds-voted and rounds-passed statistics counters. No handshake:
// every clock edge out of reset is a voting round.
module voter3
  import voter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output votes_t           num_led,
  output logic             result_led,
  output yes_count_t       yes_count,
  output logic [CNT_W-1:0] vote_cnt,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             maj_next;
  yes_count_t       cnt_next;
  logic [CNT_W-1:0] vote_cnt_next;
  logic [CNT_W-1:0] pass_cnt_next;

  majority3 u_majority3 (
    .a   (a),
    .b   (b),
    .c   (c),
    .maj (maj_next),
    .cnt (cnt_next)
  );

  // Saturating next values; each counter holds at all-ones independently.
  always_comb begin
    vote_cnt_next = vote_cnt;
    pass_cnt_next = pass_cnt;
    if (vote_cnt != CNT_MAX) begin
      vote_cnt_next = vote_cnt + CNT_ONE;
    end
    if (maj_next && (pass_cnt != CNT_MAX)) begin
      pass_cnt_next = pass_cnt + CNT_ONE;
    end
  end

  // Register the round: reset wins over sampling in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      num_led    <= '0;
      result_led <= 1'b0;
      yes_count  <= '0;
      vote_cnt   <= '0;
      pass_cnt   <= '0;
    end else begin
      num_led    <= {c, b, a};
      result_led <= maj_next;
      yes_count  <= cnt_next;
      vote_cnt   <= vote_cnt_next;
      pass_cnt   <= pass_cnt_next;
    end
  end

endmodule

// File: tb/tb_voter3.sv
// Directed bench for voter3: an 8-bit-counter instance plus a 3-bit-counter
// instance sharing the same inputs, so saturation is reachable quickly.
module tb_voter3;
  import voter_pkg::*;

  localparam int W = 28;

  // Clock / reset block
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c = 1'b0;
  always #5 CLK = ~CLK;

  votes_t     num_led, num_led3;
  logic       result_led, result_led3;
  yes_count_t yes_count, yes_count3;
  logic [7:0] vote_cnt, pass_cnt;
  logic [2:0] vote_cnt3, pass_cnt3;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {num_led, result, yes, vote8, pass8, vote3, pass3}
  logic [W-1:0] exp_q[$];

  voter3 dut (
    .CLK(CLK), .RST(RST), .a(a), .b(b), .c(c),
    .num_led(num_led), .result_led(result_led), .yes_count(yes_count),
    .vote_cnt(vote_cnt), .pass_cnt(pass_cnt)
  );

  voter3 #(.CNT_W(3)) dut3 (
    .CLK(CLK), .RST(RST), .a(a), .b(b), .c(c),
    .num_led(num_led3), .result_led(result_led3), .yes_count(yes_count3),
    .vote_cnt(vote_cnt3), .pass_cnt(pass_cnt3)
  );

  // Driver tasks: inputs change on the falling edge, outputs sampled 1 after rising.
  task automatic drive(input logic [2:0] abc, input logic rst);
    @(negedge CLK);
    a = abc[2];
    b = abc[1];
    c = abc[0];
    RST = rst;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      drive(3'b111, 1'b1);
      tick();
      checks++;
      if ({num_led, result_led, yes_count, vote_cnt, pass_cnt} !== 22'd0) begin
        errors++;
        $display("FAIL reset_dut8 cycle %0d: got %h expected 0", k,
                 {num_led, result_led, yes_count, vote_cnt, pass_cnt});
      end
      checks++;
      if ({num_led3, result_led3, yes_count3, vote_cnt3, pass_cnt3} !== 12'd0) begin
        errors++;
        $display("FAIL reset_dut3 cycle %0d: got %h expected 0", k,
                 {num_led3, result_led3, yes_count3, vote_cnt3, pass_cnt3});
      end
    end
  endtask

  task automatic test_truth_table;
    // Index i is {a,b,c}; num_led shows {c,b,a}.
    logic [2:0] tt_led [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    logic       tt_res [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] tt_yes [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [7:0] tt_pass [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
    logic [5:0] prev;
    logic [2:0] v;
    drive(3'b000, 1'b1);
    tick();
    prev = 6'd0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v, 1'b0);
      #1;
      checks++;
      if ({num_led, result_led, yes_count} !== prev) begin
        errors++;
        $display("FAIL lag_before_edge abc=%b: got %h expected %h", v,
                 {num_led, result_led, yes_count}, prev);
      end
      tick();
      checks++;
      if ({num_led, result_led, yes_count} !== {tt_led[i], tt_res[i], tt_yes[i]}) begin
        errors++;
        $display("FAIL truth abc=%b: got led=%b res=%b yes=%0d expected led=%b res=%b yes=%0d",
                 v, num_led, result_led, yes_count, tt_led[i], tt_res[i], tt_yes[i]);
      end
      checks++;
      if ({vote_cnt, pass_cnt} !== {8'(i + 1), tt_pass[i]}) begin
        errors++;
        $display("FAIL truth_counters abc=%b: got vote=%0d pass=%0d expected vote=%0d pass=%0d",
                 v, vote_cnt, pass_cnt, i + 1, tt_pass[i]);
      end
      prev = {tt_led[i], tt_res[i], tt_yes[i]};
    end
    checks++;
    if ({vote_cnt, pass_cnt} !== {8'd8, 8'd4}) begin
      errors++;
      $display("FAIL counter_totals: got vote=%0d pass=%0d expected vote=8 pass=4",
               vote_cnt, pass_cnt);
    end
  endtask

  task automatic test_saturation;
    logic [2:0] e3;
    drive(3'b000, 1'b1);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(3'b110, 1'b0);
      tick();
      e3 = (k > 7) ? 3'd7 : 3'(k);
      checks++;
      if ({vote_cnt3, pass_cnt3} !== {e3, e3}) begin
        errors++;
        $display("FAIL sat_rise round %0d: got vote=%0d pass=%0d expected %0d/%0d",
                 k, vote_cnt3, pass_cnt3, e3, e3);
      end
      checks++;
      if ({vote_cnt, pass_cnt} !== {8'(k), 8'(k)}) begin
        errors++;
        $display("FAIL sat_wide round %0d: got vote=%0d pass=%0d expected %0d/%0d",
                 k, vote_cnt, pass_cnt, k, k);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, 1'b0);
      tick();
    end
    checks++;
    if ({vote_cnt3, pass_cnt3, vote_cnt, pass_cnt} !== {3'd7, 3'd7, 8'd13, 8'd10}) begin
      errors++;
      $display("FAIL sat_hold: got %0d/%0d %0d/%0d expected 7/7 13/10",
               vote_cnt3, pass_cnt3, vote_cnt, pass_cnt);
    end
  endtask

  task automatic test_mid_reset;
    logic [2:0] seq [5] = '{3'b110, 3'b011, 3'b000, 3'b101, 3'b111};
    drive(3'b000, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b0);
      tick();
    end
    checks++;
    if ({vote_cnt, pass_cnt} !== {8'd5, 8'd4}) begin
      errors++;
      $display("FAIL mid_before: got vote=%0d pass=%0d expected 5/4", vote_cnt, pass_cnt);
    end
    drive(3'b111, 1'b1);
    tick();
    checks++;
    if ({num_led, result_led, yes_count, vote_cnt, pass_cnt} !== 22'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: got %h expected 0",
               {num_led, result_led, yes_count, vote_cnt, pass_cnt});
    end
    drive(3'b111, 1'b0);
    tick();
    checks++;
    if ({num_led, result_led, yes_count, vote_cnt, pass_cnt} !== {3'b111, 1'b1, 2'd3, 8'd1, 8'd1}) begin
      errors++;
      $display("FAIL mid_resume1: got %h expected %h",
               {num_led, result_led, yes_count, vote_cnt, pass_cnt},
               {3'b111, 1'b1, 2'd3, 8'd1, 8'd1});
    end
    drive(3'b001, 1'b0);
    tick();
    checks++;
    if ({num_led, result_led, yes_count, vote_cnt, pass_cnt} !== {3'b100, 1'b0, 2'd1, 8'd2, 8'd1}) begin
      errors++;
      $display("FAIL mid_resume2: got %h expected %h",
               {num_led, result_led, yes_count, vote_cnt, pass_cnt},
               {3'b100, 1'b0, 2'd1, 8'd2, 8'd1});
    end
  endtask

  task automatic test_random_soak;
    logic [2:0]   v;
    logic         m;
    logic [1:0]   y;
    int           votes;
    int           passes;
    logic [W-1:0] exp_w;
    logic [W-1:0] got_w;
    drive(3'b000, 1'b1);
    tick();
    votes = 0;
    passes = 0;
    for (int k = 0; k < 100; k++) begin
      v = 3'($urandom_range(0, 7));
      drive(v, 1'b0);
      y = 2'(int'(v[2]) + int'(v[1]) + int'(v[0]));
      m = (y >= 2'd2);
      votes++;
      if (m) passes++;
      exp_q.push_back({v[0], v[1], v[2], m, y, 8'(votes), 8'(passes),
                       (votes > 7) ? 3'd7 : 3'(votes),
                       (passes > 7) ? 3'd7 : 3'(passes)});
      tick();
      exp_w = exp_q.pop_front();
      got_w = {num_led, result_led, yes_count, vote_cnt, pass_cnt, vote_cnt3, pass_cnt3};
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL soak round %0d abc=%b: got %h expected %h", k, v, got_w, exp_w);
      end
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Final report
  initial begin
    test_reset();
    test_truth_table();
    test_saturation();
    test_mid_reset();
    test_random_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
